kernel_out_sink: RTL and testbench
==================================

// Module: kernel_out_sink
// PURPOSE
// Downstream consumer of the HLS kernel's ap_fifo output streams (s_out, q_out for bicg).
// Drives full_n back-pressure with a programmable throttle pattern to exercise kernel stalls.
// Folds every accepted word into a per-run 32-bit signature and checks per-run word counts.
// On ap_done, serialises the combined signature as eight 4-bit beats on data_out/data_valid.
// PARAMETERS
// DATA_W        32          stream word width (must be 32)
// EXP_S_WORDS   64          expected s stream words per run
// EXP_Q_WORDS   64          expected q stream words per run
// THROTTLE_MASK 8'h00       bit k=1 -> full_n low when thr_cnt==k (8'h00 = never stall)
// CNT_W         16          word counter width
// PORTS
// ap_clk     in   1      clock
// ap_rst     in   1      synchronous reset, active high
// ap_done    in   1      kernel run complete (1-cycle pulse)
// s_din      in   32     s stream data
// s_write    in   1      s stream write strobe
// s_full_n   out  1      s stream not-full (throttled)
// q_din      in   32     q stream data
// q_write    in   1      q stream write strobe
// q_full_n   out  1      q stream not-full (throttled)
// data_out   out  4      signature nibble, MSB nibble first
// data_valid out  1      data_out qualifier
// run_cnt    out  16     completed runs (wraps at 2^16)
// count_err  out  1      sticky: a run closed with wrong word count
// proto_err  out  1      sticky: write asserted while full_n low
// overrun    out  1      sticky: ap_done arrived during a dump
// BEHAVIOUR
// Reset and synchronicity: one clock, ap_clk; ap_rst is synchronous and active-high.
// Reset values: all outputs, accumulators, counters 0; thr_cnt=0; FSM=IDLE.
// Throttle: 3-bit thr_cnt free-runs +1 every cycle, wraps 7->0.
//   s_full_n = q_full_n = ~THROTTLE_MASK[thr_cnt]; combinational from thr_cnt.
// Accept: word accepted when write && full_n. Write with full_n=0 is dropped and sets proto_err.
// Signature update per accepted word: sig <= {sig[30:0],sig[31]} ^ din (s_sig, q_sig independent).
// Count: s_cnt/q_cnt +1 per accepted word, saturate at all-ones.
// Close of run (ap_done=1):
//   - a word accepted in the same cycle belongs to the closing run
//   - shadow <= s_sig_next ^ q_sig_next
//   - count_err set if s_cnt_next!=EXP_S_WORDS or q_cnt_next!=EXP_Q_WORDS
//   - accumulators/counters cleared to 0; run_cnt +1
//   - FSM -> DUMP, beat index=0
// FSM:
//   IDLE: data_valid=0; ap_done -> DUMP.
//   DUMP: data_valid=1 for 8 consecutive cycles starting the cycle after ap_done;
//     data_out = shadow[31-4*idx -: 4]; idx 7 -> IDLE.
//   ap_done in DUMP: overrun set, shadow reloaded, idx restarts at 0 (old dump truncated).
// Collection continues in every state; streams are never blocked by the dump.
// Reset mid-dump: data_valid=0 the cycle after reset; shadow and FSM cleared.
// Latency: ap_done at cycle T -> first beat at T+1, last beat at T+8.
// TESTING
// T1 reset: hold ap_rst 3 cycles mid-stream -> all outputs 0, full_n=1 (mask 00).
// T2 EXP_S=2/EXP_Q=1: s 0x00000001,0x00000002; q 0x80000000; ap_done
//    -> beats 8,0,0,0,0,0,0,0; count_err=0; run_cnt=1.
// T3 defaults: same stimulus as T2 -> count_err=1; beats unchanged.
// T4 THROTTLE_MASK=8'h0F: full_n low for thr_cnt 0..3, high for 4..7; write at thr_cnt=1
//    -> word dropped, proto_err=1, signature unaffected.
// T5 ap_done twice, 4 cycles apart, second run s=0x12345678 only
//    -> overrun=1; 4 beats of run 1, then 1,2,3,4,5,6,7,8; run_cnt=2.
// T6 ap_done coincident with accepted s word 0x0000000F, empty run otherwise
//    -> beats 0,0,0,0,0,0,0,F; next run starts from sig=0.

Source files
------------

// File: rtl/kernel_out_sink.sv
// Sink for the kernel's ap_fifo output streams: throttled full_n, per-run signature and
// word-count checking, and a nibble-serial dump of the combined signature on ap_done.
module kernel_out_sink #(
  parameter int          DATA_W        = 32,
  parameter int          EXP_S_WORDS   = 64,
  parameter int          EXP_Q_WORDS   = 64,
  parameter logic [7:0]  THROTTLE_MASK = 8'h00,
  parameter int          CNT_W         = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_done,
  input  logic [DATA_W-1:0] s_din,
  input  logic              s_write,
  output logic              s_full_n,
  input  logic [DATA_W-1:0] q_din,
  input  logic              q_write,
  output logic              q_full_n,
  output logic [3:0]        data_out,
  output logic              data_valid,
  output logic [15:0]       run_cnt,
  output logic              count_err,
  output logic              proto_err,
  output logic              overrun
);

  typedef enum logic {IDLE, DUMP} state_t;

  state_t            state_q;
  logic [2:0]        thr_cnt_q;
  logic [2:0]        idx_q;
  logic [DATA_W-1:0] s_sig_q, q_sig_q, shadow_q;
  logic [DATA_W-1:0] s_sig_d, q_sig_d, shadow_d;
  logic [CNT_W-1:0]  s_cnt_q, q_cnt_q, s_cnt_d, q_cnt_d;
  logic [15:0]       run_cnt_q;
  logic [3:0]        data_out_q;
  logic              data_valid_q, count_err_q, proto_err_q, overrun_q;
  logic              full_n, s_acc, q_acc, cnt_bad;

  function automatic logic [DATA_W-1:0] sig_fold(input logic [DATA_W-1:0] sig,
                                                 input logic [DATA_W-1:0] din);
    return {sig[DATA_W-2:0], sig[DATA_W-1]} ^ din;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

  function automatic logic [3:0] nibble(input logic [DATA_W-1:0] sh, input logic [2:0] idx);
    logic [DATA_W-1:0] t;
    t = sh << {idx, 2'b00};
    return t[DATA_W-1 -: 4];
  endfunction

  assign full_n   = ~THROTTLE_MASK[thr_cnt_q];
  assign s_full_n = full_n;
  assign q_full_n = full_n;

  // Next-state view of the running run: a word accepted alongside ap_done is included.
  always_comb begin
    s_acc    = s_write & full_n;
    q_acc    = q_write & full_n;
    s_sig_d  = s_acc ? sig_fold(s_sig_q, s_din) : s_sig_q;
    q_sig_d  = q_acc ? sig_fold(q_sig_q, q_din) : q_sig_q;
    s_cnt_d  = s_acc ? cnt_inc(s_cnt_q) : s_cnt_q;
    q_cnt_d  = q_acc ? cnt_inc(q_cnt_q) : q_cnt_q;
    shadow_d = s_sig_d ^ q_sig_d;
    cnt_bad  = (s_cnt_d != CNT_W'(EXP_S_WORDS)) || (q_cnt_d != CNT_W'(EXP_Q_WORDS));
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= IDLE;
      thr_cnt_q    <= '0;
      idx_q        <= '0;
      s_sig_q      <= '0;
      q_sig_q      <= '0;
      shadow_q     <= '0;
      s_cnt_q      <= '0;
      q_cnt_q      <= '0;
      run_cnt_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      count_err_q  <= 1'b0;
      proto_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      thr_cnt_q <= thr_cnt_q + 3'd1;
      if ((s_write || q_write) && !full_n)
        proto_err_q <= 1'b1;
      if (ap_done) begin
        s_sig_q      <= '0;
        q_sig_q      <= '0;
        s_cnt_q      <= '0;
        q_cnt_q      <= '0;
        shadow_q     <= shadow_d;
        run_cnt_q    <= run_cnt_q + 16'd1;
        if (cnt_bad)
          count_err_q <= 1'b1;
        // A new close while still dumping truncates the old dump.
        if (state_q == DUMP)
          overrun_q <= 1'b1;
        state_q      <= DUMP;
        idx_q        <= '0;
        data_valid_q <= 1'b1;
        data_out_q   <= shadow_d[DATA_W-1 -: 4];
      end else begin
        s_sig_q <= s_sig_d;
        q_sig_q <= q_sig_d;
        s_cnt_q <= s_cnt_d;
        q_cnt_q <= q_cnt_d;
        if (state_q == DUMP) begin
          if (idx_q == 3'd7) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            data_valid_q <= 1'b0;
            data_out_q   <= '0;
          end else begin
            idx_q      <= idx_q + 3'd1;
            data_out_q <= nibble(shadow_q, idx_q + 3'd1);
          end
        end
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign run_cnt    = run_cnt_q;
  assign count_err  = count_err_q;
  assign proto_err  = proto_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_kernel_out_sink.sv
// Bench for kernel_out_sink: three instances (exact counts, defaults, throttled) share one
// stimulus stream; directed scenarios plus a randomized run against a run-level model.
module tb_kernel_out_sink;

  logic        ap_clk = 1'b0, ap_rst = 1'b0, ap_done = 1'b0;
  logic        s_write = 1'b0, q_write = 1'b0;
  logic [31:0] s_din = '0, q_din = '0;
  logic [2:0]  sfn, qfn, dv, cerr, perr, ovr;
  logic [3:0]  dout [3];
  logic [15:0] rc   [3];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 ap_clk = ~ap_clk;

  kernel_out_sink #(.DATA_W(32), .EXP_S_WORDS(2), .EXP_Q_WORDS(1), .THROTTLE_MASK(8'h00), .CNT_W(16)) u_d0 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_done(ap_done),
    .s_din(s_din), .s_write(s_write), .s_full_n(sfn[0]),
    .q_din(q_din), .q_write(q_write), .q_full_n(qfn[0]),
    .data_out(dout[0]), .data_valid(dv[0]), .run_cnt(rc[0]),
    .count_err(cerr[0]), .proto_err(perr[0]), .overrun(ovr[0]));

  kernel_out_sink #(.DATA_W(32), .EXP_S_WORDS(64), .EXP_Q_WORDS(64), .THROTTLE_MASK(8'h00), .CNT_W(16)) u_d1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_done(ap_done),
    .s_din(s_din), .s_write(s_write), .s_full_n(sfn[1]),
    .q_din(q_din), .q_write(q_write), .q_full_n(qfn[1]),
    .data_out(dout[1]), .data_valid(dv[1]), .run_cnt(rc[1]),
    .count_err(cerr[1]), .proto_err(perr[1]), .overrun(ovr[1]));

  kernel_out_sink #(.DATA_W(32), .EXP_S_WORDS(64), .EXP_Q_WORDS(64), .THROTTLE_MASK(8'h0F), .CNT_W(16)) u_d2 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_done(ap_done),
    .s_din(s_din), .s_write(s_write), .s_full_n(sfn[2]),
    .q_din(q_din), .q_write(q_write), .q_full_n(qfn[2]),
    .data_out(dout[2]), .data_valid(dv[2]), .run_cnt(rc[2]),
    .count_err(cerr[2]), .proto_err(perr[2]), .overrun(ovr[2]));

  // Run-level reference model, one slot per instance.
  int          exps [3] = '{2, 64, 64};
  int          expq [3] = '{1, 64, 64};
  logic [7:0]  msk  [3] = '{8'h00, 8'h00, 8'h0F};
  int          m_cyc;
  logic [31:0] m_ss [3], m_qs [3], m_sh [3];
  int          m_sc [3], m_qc [3], m_pos [3], m_run [3];
  bit          m_ce [3], m_pe [3], m_ov [3];

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return (x << 1) | (x >> 31);
  endfunction

  task automatic step(input logic sw, input logic [31:0] sd, input logic qw,
                      input logic [31:0] qd, input logic dn, input logic rs);
    @(negedge ap_clk);
    s_write = sw; s_din = sd; q_write = qw; q_din = qd; ap_done = dn; ap_rst = rs;
    @(posedge ap_clk);
    if (rs) begin
      m_cyc = 0;
      for (int k = 0; k < 3; k++) begin
        m_ss[k] = 0; m_qs[k] = 0; m_sh[k] = 0; m_sc[k] = 0; m_qc[k] = 0;
        m_pos[k] = 8; m_run[k] = 0; m_ce[k] = 0; m_pe[k] = 0; m_ov[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit fn;
        fn = !msk[k][m_cyc % 8];
        if ((sw || qw) && !fn) m_pe[k] = 1;
        if (sw && fn) begin m_ss[k] = rotl1(m_ss[k]) ^ sd; if (m_sc[k] < 65535) m_sc[k]++; end
        if (qw && fn) begin m_qs[k] = rotl1(m_qs[k]) ^ qd; if (m_qc[k] < 65535) m_qc[k]++; end
        if (dn) begin
          if (m_pos[k] < 8) m_ov[k] = 1;
          m_sh[k] = m_ss[k] ^ m_qs[k];
          if (m_sc[k] != exps[k] || m_qc[k] != expq[k]) m_ce[k] = 1;
          m_ss[k] = 0; m_qs[k] = 0; m_sc[k] = 0; m_qc[k] = 0;
          m_run[k] = (m_run[k] + 1) % 65536;
          m_pos[k] = 0;
        end else if (m_pos[k] < 8) begin
          m_pos[k]++;
        end
      end
      m_cyc++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    do_reset(2);
    idle(2);
    step(1, 32'hCAFEF00D, 1, 32'h0BADBEEF, 0, 0);
    step(1, 32'h11112222, 0, 0, 1, 0);
    step(1, 32'h33334444, 1, 32'h5555AAAA, 0, 0);
    step(1, $urandom, 1, $urandom, 0, 1);
    chk_cnt++; if (dv[0] !== 1'b0) $display("FAIL reset_mid_dump_valid got %b exp 0", dv[0]); else pass_cnt++;
    step(1, $urandom, 1, $urandom, 0, 1);
    step(1, $urandom, 1, $urandom, 0, 1);
    chk_cnt++;
    if ({dv[0], dout[0], rc[0], cerr[0], perr[0], ovr[0]} !== 24'h0)
      $display("FAIL reset_outputs got dv=%b do=%h rc=%0d ce=%b pe=%b ov=%b exp all 0",
               dv[0], dout[0], rc[0], cerr[0], perr[0], ovr[0]);
    else pass_cnt++;
    chk_cnt++; if ({sfn[0], qfn[0]} !== 2'b11) $display("FAIL reset_full_n got %b%b exp 11", sfn[0], qfn[0]); else pass_cnt++;
    chk_cnt++; if ({sfn[2], perr[2]} !== 2'b00) $display("FAIL reset_thr_d2 got full_n=%b pe=%b exp 0 0", sfn[2], perr[2]); else pass_cnt++;
  endtask

  task automatic test_count_check();
    logic [3:0] exp_b [8] = '{4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    do_reset(2);
    idle(4);
    step(1, 32'h00000001, 0, 0, 0, 0);
    step(1, 32'h00000002, 0, 0, 0, 0);
    step(0, 0, 1, 32'h80000000, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) idle(1);
      for (int k = 0; k < 3; k++) begin
        chk_cnt++;
        if ({dv[k], dout[k]} !== {1'b1, exp_b[i]})
          $display("FAIL count_beat%0d_d%0d got v=%b %h exp v=1 %h", i, k, dv[k], dout[k], exp_b[i]);
        else pass_cnt++;
      end
    end
    chk_cnt++; if (cerr !== 3'b110) $display("FAIL count_err got %b exp 110", cerr); else pass_cnt++;
    chk_cnt++; if (rc[0] !== 16'd1) $display("FAIL count_run_cnt got %0d exp 1", rc[0]); else pass_cnt++;
    idle(1);
    chk_cnt++; if ({dv, dout[0]} !== 7'h0) $display("FAIL count_dump_end got v=%b do=%h exp 0", dv, dout[0]); else pass_cnt++;
  endtask

  task automatic test_throttle();
    logic [3:0] exp_b [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) idle(1);
      chk_cnt++;
      if ({sfn[2], qfn[2], sfn[0]} !== {(i >= 4), (i >= 4), 1'b1})
        $display("FAIL thr_full_n_%0d got %b%b%b exp %b%b1", i, sfn[2], qfn[2], sfn[0], i >= 4, i >= 4);
      else pass_cnt++;
    end
    idle(2);
    step(1, 32'hDEADBEEF, 0, 0, 0, 0);
    chk_cnt++; if ({perr[2], perr[0]} !== 2'b10) $display("FAIL thr_proto_err got d2=%b d0=%b exp 1 0", perr[2], perr[0]); else pass_cnt++;
    idle(2);
    step(1, 32'h0000000F, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) idle(1);
      chk_cnt++;
      if ({dv[2], dout[2]} !== {1'b1, exp_b[i]})
        $display("FAIL thr_beat%0d got v=%b %h exp v=1 %h", i, dv[2], dout[2], exp_b[i]);
      else pass_cnt++;
    end
    idle(1);
  endtask

  task automatic test_overrun();
    logic [3:0] exp_b [12] = '{4'hA, 4'h5, 4'hA, 4'h5, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    do_reset(1);
    idle(4);
    step(1, 32'hA5A5A5A5, 0, 0, 0, 0);
    for (int j = 0; j < 12; j++) begin
      step(j == 2, 32'h12345678, 0, 0, (j == 0) || (j == 4), 0);
      for (int k = 0; k < 3; k++) begin
        chk_cnt++;
        if ({dv[k], dout[k]} !== {1'b1, exp_b[j]})
          $display("FAIL ovr_beat%0d_d%0d got v=%b %h exp v=1 %h", j, k, dv[k], dout[k], exp_b[j]);
        else pass_cnt++;
      end
    end
    chk_cnt++; if (ovr !== 3'b111) $display("FAIL ovr_flag got %b exp 111", ovr); else pass_cnt++;
    chk_cnt++; if (rc[0] !== 16'd2) $display("FAIL ovr_run_cnt got %0d exp 2", rc[0]); else pass_cnt++;
    idle(1);
    chk_cnt++; if (dv !== 3'b000) $display("FAIL ovr_dump_end got %b exp 000", dv); else pass_cnt++;
  endtask

  task automatic test_done_same_cycle();
    logic [3:0] exp_a [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
    logic [3:0] exp_b [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    do_reset(1);
    idle(4);
    step(1, 32'h0000000F, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 1) step(1, 32'h00000001, 0, 0, 0, 0);
      else if (i > 1) idle(1);
      chk_cnt++;
      if ({dv[0], dout[0]} !== {1'b1, exp_a[i]})
        $display("FAIL same_beat%0d got v=%b %h exp v=1 %h", i, dv[0], dout[0], exp_a[i]);
      else pass_cnt++;
    end
    idle(1);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) idle(1);
      chk_cnt++;
      if ({dv[0], dout[0]} !== {1'b1, exp_b[i]})
        $display("FAIL next_run_beat%0d got v=%b %h exp v=1 %h", i, dv[0], dout[0], exp_b[i]);
      else pass_cnt++;
    end
    chk_cnt++; if (ovr[0] !== 1'b0) $display("FAIL same_no_overrun got %b exp 0", ovr[0]); else pass_cnt++;
    idle(1);
  endtask

  task automatic test_random();
    logic [26:0] got, exp;
    do_reset(2);
    for (int n = 0; n < 600; n++) begin
      step(($urandom % 3) != 0, $urandom, ($urandom % 3) != 0, $urandom, ($urandom % 14) == 0, 0);
      for (int k = 0; k < 3; k++) begin
        bit         e_fn, e_dv;
        logic [3:0] e_nib;
        e_fn  = !msk[k][m_cyc % 8];
        e_dv  = m_pos[k] < 8;
        e_nib = e_dv ? 4'((m_sh[k] >> (28 - 4 * m_pos[k])) & 32'hF) : 4'h0;
        got = {sfn[k], qfn[k], dv[k], dout[k], rc[k], cerr[k], perr[k], ovr[k]};
        exp = {e_fn, e_fn, e_dv, e_nib, 16'(m_run[k]), m_ce[k], m_pe[k], m_ov[k]};
        chk_cnt++;
        if (got !== exp) $display("FAIL random_c%0d_d%0d got %h exp %h", n, k, got, exp);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count_check();
    test_throttle();
    test_overrun();
    test_done_same_cycle();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
